// File: rtl/reload_down_timer.sv
// Programmable down-counting timer.
// A period (in ticks) and a prescale (clock cycles per tick, minus 1) are
// loaded through a valid/ready config port. Once started, the timer counts
// ticks down to expiry, either once (one-shot) or repeatedly (periodic), and
// raises a one-cycle expire pulse plus a sticky irq. An expiry that lands
// while irq is still pending also sets the sticky overrun flag.
module reload_down_timer #(
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WIDTH-1:0]     cfg_period,
  input  logic [PRE_WIDTH-1:0] cfg_prescale,
  input  logic                 cfg_periodic,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 irq_clear,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 expire,
  output logic                 irq,
  output logic                 overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     period_q;
  logic [PRE_WIDTH-1:0] prescale_q;
  logic                 periodic_q;
  logic [PRE_WIDTH-1:0] pre_cnt;

  logic                 cfg_accept;
  logic [WIDTH-1:0]     eff_period;
  logic [PRE_WIDTH-1:0] eff_prescale;
  logic                 tick;
  logic                 exp_now;

  // Config is only taken while idle so a running period can never change
  // under the counter; the offering side keeps it pending until then.
  assign cfg_ready  = (state == IDLE);
  assign cfg_accept = cfg_valid & cfg_ready;

  // A config accepted in the same cycle as start must take effect from that
  // start, so the start path looks through to the incoming fields.
  assign eff_period   = cfg_accept ? cfg_period   : period_q;
  assign eff_prescale = cfg_accept ? cfg_prescale : prescale_q;

  // A tick is suppressed by stop so an abort always beats the final tick.
  assign tick    = (state == RUN) && !stop && (pre_cnt == '0);
  assign exp_now = tick && (count == WIDTH'(1));

  // Capture accepted configuration fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
    end else if (cfg_accept) begin
      period_q   <= cfg_period;
      prescale_q <= cfg_prescale;
      periodic_q <= cfg_periodic;
    end
  end

  // Main FSM: start/stop handling, prescaler, period countdown and expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      pre_cnt <= '0;
      busy    <= 1'b0;
      expire  <= 1'b0;
    end else begin
      expire <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && (eff_period != '0)) begin
            count   <= eff_period;
            pre_cnt <= eff_prescale;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            count   <= '0;
            pre_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (tick) begin
            pre_cnt <= prescale_q;
            if (exp_now) begin
              expire <= 1'b1;
              if (periodic_q) begin
                count <= period_q;
              end else begin
                count <= '0;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              count <= count - WIDTH'(1);
            end
          end else begin
            pre_cnt <= pre_cnt - PRE_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: an expiry always wins over a clear in the same cycle, and
  // in that case overrun is left as it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (exp_now) begin
        irq <= 1'b1;
        if (irq && !irq_clear) begin
          overrun <= 1'b1;
        end
      end else if (irq_clear) begin
        irq     <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reload_down_timer.sv
// Testbench for reload_down_timer: directed scenarios push expected expiry
// records into a queue; a monitor pops and compares on every expire pulse.
module tb_reload_down_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_prescale;
  logic        cfg_periodic;
  logic        start;
  logic        stop;
  logic        irq_clear;
  logic [15:0] count;
  logic        busy;
  logic        expire;
  logic        irq;
  logic        overrun;

  typedef struct {
    int          cyc;
    logic [15:0] count;
    logic        busy;
    logic        irq;
    logic        overrun;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   k;
  int   k2;

  reload_down_timer #(.WIDTH(16), .PRE_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .irq_clear    (irq_clear),
    .count        (count),
    .busy         (busy),
    .expire       (expire),
    .irq          (irq),
    .overrun      (overrun)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Edge counter used to timestamp expiries
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)",
                  name, actual, expected, cyc);
  endtask

  task automatic push_exp(input int c, input logic [15:0] cnt, input logic b,
                          input logic i, input logic o);
    exp_t e;
    e.cyc = c; e.count = cnt; e.busy = b; e.irq = i; e.overrun = o;
    exp_q.push_back(e);
  endtask

  // Offer a config for one cycle (block must be idle)
  task automatic apply_stimulus(input logic [15:0] p, input logic [7:0] s,
                                input logic per);
    cfg_valid = 1'b1; cfg_period = p; cfg_prescale = s; cfg_periodic = per;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Pulse start; returns the edge index that samples it
  task automatic do_start(output int kk);
    start = 1'b1;
    kk = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic pulse_clear();
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every expire pulse must match the next expected record
  always @(negedge clk) begin
    if (rst_n && expire) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("[TB] FAIL unexpected_expire: expire=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("expire_cycle", cyc, mon_e.cyc);
        check_output("expire_count", count, mon_e.count);
        check_output("expire_busy", busy, mon_e.busy);
        check_output("expire_irq", irq, mon_e.irq);
        check_output("expire_overrun", overrun, mon_e.overrun);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios
  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_prescale = '0;
    cfg_periodic = 1'b0; start = 1'b0; stop = 1'b0; irq_clear = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_count", count, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_expire", expire, 0);
    check_output("reset_irq", irq, 0);
    check_output("reset_overrun", overrun, 0);
    check_output("reset_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // One-shot P=3 S=0
    apply_stimulus(16'd3, 8'd0, 1'b0);
    do_start(k);
    push_exp(k + 3, 16'd0, 1'b0, 1'b1, 1'b0);
    check_output("oneshot_count0", count, 3);
    check_output("oneshot_busy", busy, 1);
    @(negedge clk); check_output("oneshot_count1", count, 2);
    @(negedge clk); check_output("oneshot_count2", count, 1);
    wait_until(k + 4);
    check_output("oneshot_irq_sticky", irq, 1);
    check_output("oneshot_idle", busy, 0);
    pulse_clear();
    check_output("clear_irq", irq, 0);

    // Periodic P=2 S=2: expiries every 6 cycles, overrun from the second
    apply_stimulus(16'd2, 8'd2, 1'b1);
    do_start(k);
    push_exp(k + 6, 16'd2, 1'b1, 1'b1, 1'b0);
    push_exp(k + 12, 16'd2, 1'b1, 1'b1, 1'b1);
    push_exp(k + 18, 16'd2, 1'b1, 1'b1, 1'b1);
    check_output("periodic_count0", count, 2);
    wait_until(k + 3);
    check_output("periodic_first_tick", count, 1);
    wait_until(k + 19);
    do_stop();
    check_output("periodic_stop_busy", busy, 0);
    check_output("periodic_stop_count", count, 0);
    check_output("periodic_irq_sticky", irq, 1);
    check_output("periodic_overrun_sticky", overrun, 1);
    pulse_clear();
    check_output("clear_alone_irq", irq, 0);
    check_output("clear_alone_overrun", overrun, 0);

    // Handshake: config held during RUN is not taken
    apply_stimulus(16'd4, 8'd0, 1'b1);
    do_start(k);
    push_exp(k + 4, 16'd4, 1'b1, 1'b1, 1'b0);
    cfg_valid = 1'b1; cfg_period = 16'd9; cfg_prescale = 8'd3; cfg_periodic = 1'b0;
    #1;
    check_output("run_cfg_ready", cfg_ready, 0);
    wait_until(k + 5);
    do_stop();
    check_output("after_stop_cfg_ready", cfg_ready, 1);
    check_output("after_stop_busy", busy, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    pulse_clear();
    do_start(k2);
    check_output("pending_cfg_count", count, 9);
    check_output("pending_cfg_busy", busy, 1);
    do_stop();
    check_output("stop_run_busy", busy, 0);

    // Config+start same cycle, P=1, then restart in the expire cycle
    cfg_valid = 1'b1; cfg_period = 16'd1; cfg_prescale = 8'd0; cfg_periodic = 1'b0;
    start = 1'b1;
    k = cyc + 1;
    push_exp(k + 1, 16'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    do_start(k2);
    push_exp(k2 + 1, 16'd0, 1'b0, 1'b1, 1'b1);
    wait_until(k2 + 2);
    pulse_clear();
    check_output("clear_after_restart_irq", irq, 0);
    check_output("clear_after_restart_overrun", overrun, 0);

    // Start with P=0 is ignored
    apply_stimulus(16'd0, 8'd0, 1'b0);
    do_start(k);
    check_output("p0_busy", busy, 0);
    check_output("p0_count", count, 0);

    // Stop coincident with the final tick
    apply_stimulus(16'd2, 8'd1, 1'b0);
    do_start(k);
    wait_until(k + 3);
    do_stop();
    check_output("stop_final_busy", busy, 0);
    check_output("stop_final_irq", irq, 0);
    check_output("stop_final_expire", expire, 0);
    repeat (4) @(negedge clk);

    // Expire coincident with irq_clear while irq=1
    apply_stimulus(16'd1, 8'd1, 1'b1);
    do_start(k);
    push_exp(k + 2, 16'd1, 1'b1, 1'b1, 1'b0);
    push_exp(k + 4, 16'd1, 1'b1, 1'b1, 1'b0);
    push_exp(k + 6, 16'd1, 1'b1, 1'b1, 1'b1);
    wait_until(k + 3);
    pulse_clear();
    wait_until(k + 6);
    do_stop();
    check_output("coincide_stop_busy", busy, 0);
    pulse_clear();

    // Maximum period
    apply_stimulus(16'hFFFF, 8'd0, 1'b0);
    do_start(k);
    push_exp(k + 65535, 16'd0, 1'b0, 1'b1, 1'b0);
    wait_until(k + 65536);
    check_output("maxp_busy", busy, 0);

    // Asynchronous reset mid-run (irq is set going in)
    apply_stimulus(16'd8, 8'd0, 1'b0);
    do_start(k);
    wait_until(k + 3);
    check_output("prereset_count", count, 5);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_count", count, 0);
    check_output("async_reset_busy", busy, 0);
    check_output("async_reset_irq", irq, 0);
    check_output("async_reset_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_output("post_reset_busy", busy, 0);

    check_output("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
